// File: rtl/frame_color_stats.sv
// frame_color_stats
//   Per-frame colour statistics for the camera pixel stream, in the Pclock domain.
//   Counts red-, green- and blue-dominant RGB444 pixels over one frame. At the end of
//   the frame it picks the dominant colour and publishes it with a valid/ack handshake.
//
//   Ports
//     Pclock       in   pixel clock
//     Reset        in   synchronous active-high reset
//     PixelData    in   RGB444 pixel {R,G,B}
//     PAddress     in   pixel address X + Y*H_RES
//     WPixel       in   pixel valid strobe
//     Vsync        in   frame sync, high during vertical blanking
//     ResultAck    in   consumer acknowledge
//     Color        out  0 none, 1 red, 2 green, 3 blue
//     RCount       out  red-dominant pixels in the last published frame
//     GCount       out  green-dominant pixels in the last published frame
//     BCount       out  blue-dominant pixels in the last published frame
//     ResultValid  out  unacknowledged result present
//     Overrun      out  a result was overwritten before being acked (sticky until ack)
//
//   state      | meaning
//   WAIT_FRAME | idle, waiting for a Vsync fall to start a frame
//   ACCUM      | counting dominant pixels until Vsync rises
//   COMPARE    | pick the winning channel from the counters
//   PUBLISH    | load result registers and raise ResultValid
module frame_color_stats #(
   parameter int          H_RES      = 176,
   parameter int          V_RES      = 144,
   parameter logic [3:0]  MIN_LEVEL  = 4'd8,
   parameter logic [14:0] MIN_PIXELS = 15'd500
) (
   input  logic        Pclock,
   input  logic        Reset,
   input  logic [11:0] PixelData,
   input  logic [14:0] PAddress,
   input  logic        WPixel,
   input  logic        Vsync,
   input  logic        ResultAck,
   output logic [1:0]  Color,
   output logic [14:0] RCount,
   output logic [14:0] GCount,
   output logic [14:0] BCount,
   output logic        ResultValid,
   output logic        Overrun
);

   localparam logic [14:0] N_PIX   = 15'(H_RES * V_RES);
   localparam logic [14:0] CNT_MAX = 15'h7FFF;

   typedef enum logic [1:0] {WAIT_FRAME, ACCUM, COMPARE, PUBLISH} state_e;

   state_e      state_q, state_d;
   logic        vsync_prev_q;
   logic [14:0] r_cnt_q, r_cnt_d, g_cnt_q, g_cnt_d, b_cnt_q, b_cnt_d;
   logic [1:0]  win_q, win_d;
   logic [1:0]  color_q, color_d;
   logic [14:0] rcount_q, rcount_d, gcount_q, gcount_d, bcount_q, bcount_d;
   logic        valid_q, valid_d;
   logic        over_q, over_d;

   logic        fall, rise;
   logic [3:0]  r_px, g_px, b_px;
   logic        pix_ok, is_r, is_g, is_b;

   assign fall = !Vsync && vsync_prev_q;
   assign rise = Vsync && !vsync_prev_q;

   assign r_px = PixelData[11:8];
   assign g_px = PixelData[7:4];
   assign b_px = PixelData[3:0];

   // Equal top channels fail the strict compares, so such pixels count nowhere.
   assign pix_ok = WPixel && (PAddress < N_PIX);
   assign is_r   = (r_px >= MIN_LEVEL) && (r_px > g_px) && (r_px > b_px);
   assign is_g   = (g_px >= MIN_LEVEL) && (g_px > r_px) && (g_px > b_px);
   assign is_b   = (b_px >= MIN_LEVEL) && (b_px > r_px) && (b_px > g_px);

   always_comb begin
      state_d  = state_q;
      r_cnt_d  = r_cnt_q;
      g_cnt_d  = g_cnt_q;
      b_cnt_d  = b_cnt_q;
      win_d    = win_q;
      color_d  = color_q;
      rcount_d = rcount_q;
      gcount_d = gcount_q;
      bcount_d = bcount_q;
      valid_d  = valid_q;
      over_d   = over_q;

      // Ack outside PUBLISH retires the result; inside PUBLISH the new result wins.
      if (ResultAck && valid_q && (state_q != PUBLISH)) begin
         valid_d = 1'b0;
         over_d  = 1'b0;
      end

      case (state_q)
         WAIT_FRAME: begin
            if (fall) begin
               r_cnt_d = '0;
               g_cnt_d = '0;
               b_cnt_d = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            // A pixel arriving in the rise cycle still belongs to this frame.
            if (pix_ok) begin
               if (is_r && (r_cnt_q != CNT_MAX)) r_cnt_d = r_cnt_q + 15'd1;
               if (is_g && (g_cnt_q != CNT_MAX)) g_cnt_d = g_cnt_q + 15'd1;
               if (is_b && (b_cnt_q != CNT_MAX)) b_cnt_d = b_cnt_q + 15'd1;
            end
            if (rise) state_d = COMPARE;
         end
         COMPARE: begin
            if ((r_cnt_q > g_cnt_q) && (r_cnt_q > b_cnt_q) && (r_cnt_q >= MIN_PIXELS))
               win_d = 2'd1;
            else if ((g_cnt_q > r_cnt_q) && (g_cnt_q > b_cnt_q) && (g_cnt_q >= MIN_PIXELS))
               win_d = 2'd2;
            else if ((b_cnt_q > r_cnt_q) && (b_cnt_q > g_cnt_q) && (b_cnt_q >= MIN_PIXELS))
               win_d = 2'd3;
            else
               win_d = 2'd0;
            state_d = PUBLISH;
         end
         PUBLISH: begin
            color_d  = win_q;
            rcount_d = r_cnt_q;
            gcount_d = g_cnt_q;
            bcount_d = b_cnt_q;
            valid_d  = 1'b1;
            if (ResultAck)    over_d = 1'b0;
            else if (valid_q) over_d = 1'b1;
            state_d  = WAIT_FRAME;
         end
         default: state_d = WAIT_FRAME;
      endcase
   end

   always_ff @(posedge Pclock) begin
      if (Reset) begin
         state_q      <= WAIT_FRAME;
         vsync_prev_q <= 1'b0;
         r_cnt_q      <= '0;
         g_cnt_q      <= '0;
         b_cnt_q      <= '0;
         win_q        <= '0;
         color_q      <= '0;
         rcount_q     <= '0;
         gcount_q     <= '0;
         bcount_q     <= '0;
         valid_q      <= 1'b0;
         over_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vsync_prev_q <= Vsync;
         r_cnt_q      <= r_cnt_d;
         g_cnt_q      <= g_cnt_d;
         b_cnt_q      <= b_cnt_d;
         win_q        <= win_d;
         color_q      <= color_d;
         rcount_q     <= rcount_d;
         gcount_q     <= gcount_d;
         bcount_q     <= bcount_d;
         valid_q      <= valid_d;
         over_q       <= over_d;
      end
   end

   assign Color       = color_q;
   assign RCount      = rcount_q;
   assign GCount      = gcount_q;
   assign BCount      = bcount_q;
   assign ResultValid = valid_q;
   assign Overrun     = over_q;

endmodule

// File: tb/tb_frame_color_stats.sv
// Bench for frame_color_stats: a table of single-colour frames, hand-written sequences
// for reset, overrun and handshake corners, and randomized frames checked against a
// pixel-counting reference model.
module tb_frame_color_stats;

   localparam int NPIX = 176 * 144;

   logic        Pclock = 1'b0;
   logic        Reset = 1'b1;
   logic [11:0] PixelData = '0;
   logic [14:0] PAddress = '0;
   logic        WPixel = 1'b0;
   logic        Vsync = 1'b0;
   logic        ResultAck = 1'b0;
   logic [1:0]  Color;
   logic [14:0] RCount, GCount, BCount;
   logic        ResultValid, Overrun;

   frame_color_stats dut (
      .Pclock(Pclock), .Reset(Reset), .PixelData(PixelData), .PAddress(PAddress),
      .WPixel(WPixel), .Vsync(Vsync), .ResultAck(ResultAck), .Color(Color),
      .RCount(RCount), .GCount(GCount), .BCount(BCount),
      .ResultValid(ResultValid), .Overrun(Overrun)
   );

   always #5 Pclock = ~Pclock;

   int checks = 0;
   int failures = 0;

   // reference model: live frame counts, published result, handshake flags
   int mr, mg, mb;
   int pr, pg, pb, pc;
   bit m_valid, m_over, m_accum;

   typedef struct {
      logic [11:0] pix;
      int addr;
      int n;
      int er, eg, eb, ecol;
   } vec_t;
   vec_t vecs[11];

   task automatic tick();
      @(posedge Pclock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int classify(input logic [11:0] p);
      int r, g, b;
      r = int'(p[11:8]);
      g = int'(p[7:4]);
      b = int'(p[3:0]);
      if (r >= 8 && r > g && r > b) return 1;
      if (g >= 8 && g > r && g > b) return 2;
      if (b >= 8 && b > r && b > g) return 3;
      return 0;
   endfunction

   function automatic int winner(input int r, input int g, input int b);
      if (r > g && r > b && r >= 500) return 1;
      if (g > r && g > b && g >= 500) return 2;
      if (b > r && b > g && b >= 500) return 3;
      return 0;
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= 32767) ? 32767 : v + 1;
   endfunction

   task automatic model_pixel(input logic [11:0] p, input int addr);
      if (m_accum && addr < NPIX) begin
         case (classify(p))
            1: mr = sat_inc(mr);
            2: mg = sat_inc(mg);
            3: mb = sat_inc(mb);
            default: ;
         endcase
      end
   endtask

   task automatic model_publish(input bit ack);
      if (ack) m_over = 0;
      else if (m_valid) m_over = 1;
      m_valid = 1;
      pr = mr; pg = mg; pb = mb;
      pc = winner(mr, mg, mb);
   endtask

   task automatic chk_outputs(input string name);
      chk({name, "_color"}, int'(Color), pc);
      chk({name, "_rcount"}, int'(RCount), pr);
      chk({name, "_gcount"}, int'(GCount), pg);
      chk({name, "_bcount"}, int'(BCount), pb);
      chk({name, "_valid"}, int'(ResultValid), int'(m_valid));
      chk({name, "_overrun"}, int'(Overrun), int'(m_over));
   endtask

   task automatic do_reset(input string name);
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         PixelData = 12'($urandom);
         PAddress  = 15'($urandom);
         WPixel    = 1'($urandom);
         Vsync     = 1'($urandom);
         ResultAck = 1'($urandom);
         tick();
      end
      Reset = 1'b0;
      WPixel = 1'b0; Vsync = 1'b0; ResultAck = 1'b0;
      mr = 0; mg = 0; mb = 0; pr = 0; pg = 0; pb = 0; pc = 0;
      m_valid = 0; m_over = 0; m_accum = 0;
      chk_outputs(name);
   endtask

   task automatic push(input logic [11:0] p, input int addr);
      PixelData = p;
      PAddress  = 15'(addr);
      WPixel    = 1'b1;
      tick();
      WPixel    = 1'b0;
      model_pixel(p, addr);
   endtask

   task automatic start_frame();
      WPixel = 1'b0;
      Vsync = 1'b1;
      tick();
      tick();
      Vsync = 1'b0;
      tick();
      m_accum = 1;
      mr = 0; mg = 0; mb = 0;
   endtask

   task automatic end_frame(input string name, input bit ack_pub, input bit rise_pix,
                            input logic [11:0] p, input int addr);
      bit was_valid;
      was_valid = m_valid;
      Vsync = 1'b1;
      if (rise_pix) begin
         PixelData = p;
         PAddress  = 15'(addr);
         WPixel    = 1'b1;
      end
      tick();
      WPixel = 1'b0;
      if (rise_pix) model_pixel(p, addr);
      m_accum = 0;
      if (!was_valid) chk({name, "_lat0"}, int'(ResultValid), 0);
      tick();
      if (!was_valid) chk({name, "_lat1"}, int'(ResultValid), 0);
      ResultAck = ack_pub;
      tick();
      ResultAck = 1'b0;
      model_publish(ack_pub);
      chk_outputs(name);
   endtask

   task automatic ack(input string name);
      ResultAck = 1'b1;
      tick();
      ResultAck = 1'b0;
      if (m_valid) begin
         m_valid = 0;
         m_over = 0;
      end
      chk({name, "_valid"}, int'(ResultValid), int'(m_valid));
      chk({name, "_overrun"}, int'(Overrun), int'(m_over));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{12'hF00, 0,     600, 600, 0,   0,   1};
      vecs[1]  = '{12'h0F0, 10,    500, 0,   500, 0,   2};
      vecs[2]  = '{12'h00F, 10,    499, 0,   0,   499, 0};
      vecs[3]  = '{12'hF00, NPIX,  5,   0,   0,   0,   0};
      vecs[4]  = '{12'h700, 0,     20,  0,   0,   0,   0};
      vecs[5]  = '{12'h880, 0,     20,  0,   0,   0,   0};
      vecs[6]  = '{12'h987, 3,     500, 500, 0,   0,   1};
      vecs[7]  = '{12'h8F0, 7,     3,   0,   3,   0,   0};
      vecs[8]  = '{12'h0FF, 7,     7,   0,   0,   0,   0};
      vecs[9]  = '{12'hF00, NPIX-1, 2,  2,   0,   0,   0};
      vecs[10] = '{12'h5A9, 100,   501, 0,   501, 0,   2};

      // reset with random inputs, then a stream before the first fall is not counted
      do_reset("reset");
      for (int i = 0; i < 40; i++) push(12'hF00, i);
      Vsync = 1'b1;
      for (int i = 0; i < 20; i++) push(12'h00F, i);
      start_frame();
      end_frame("prefall", 0, 0, 12'h0, 0);
      chk("prefall_rcount0", int'(RCount), 0);
      ack("prefall_ack");

      // full frame of red
      start_frame();
      for (int a = 0; a < NPIX; a++) push(12'hF00, a);
      end_frame("full_red", 0, 0, 12'h0, 0);
      chk("full_red_r", int'(RCount), 25344);
      chk("full_red_c", int'(Color), 1);
      ack("full_red_ack");

      // table of single-colour frames
      foreach (vecs[k]) begin
         start_frame();
         for (int i = 0; i < vecs[k].n; i++) push(vecs[k].pix, vecs[k].addr);
         end_frame($sformatf("tbl%0d", k), 0, 0, 12'h0, 0);
         chk($sformatf("tbl%0d_r", k), int'(RCount), vecs[k].er);
         chk($sformatf("tbl%0d_g", k), int'(GCount), vecs[k].eg);
         chk($sformatf("tbl%0d_b", k), int'(BCount), vecs[k].eb);
         chk($sformatf("tbl%0d_c", k), int'(Color), vecs[k].ecol);
         ack($sformatf("tbl%0d_ack", k));
      end

      // mixed frames
      start_frame();
      for (int i = 0; i < 1000; i++) push(12'h0F0, i);
      for (int i = 0; i < 999; i++) push(12'h00F, 1000 + i);
      for (int i = 0; i < 50; i++) push(12'h000, 2000 + i);
      end_frame("mix_g", 0, 0, 12'h0, 0);
      chk("mix_g_c", int'(Color), 2);
      ack("mix_g_ack");
      start_frame();
      for (int i = 0; i < 600; i++) push(12'hF00, i);
      for (int i = 0; i < 600; i++) push(12'h0F0, 600 + i);
      end_frame("tie", 0, 0, 12'h0, 0);
      chk("tie_c", int'(Color), 0);
      ack("tie_ack");
      start_frame();
      for (int i = 0; i < 400; i++) push(12'h00F, i);
      end_frame("few_b", 0, 0, 12'h0, 0);
      chk("few_b_b", int'(BCount), 400);
      chk("few_b_c", int'(Color), 0);
      ack("few_b_ack");

      // overrun, ack clears, ack coinciding with publish
      start_frame();
      for (int i = 0; i < 600; i++) push(12'hF00, i);
      end_frame("ovr_a", 0, 0, 12'h0, 0);
      start_frame();
      for (int i = 0; i < 520; i++) push(12'h0F0, i);
      end_frame("ovr_b", 0, 0, 12'h0, 0);
      chk("ovr_b_over", int'(Overrun), 1);
      chk("ovr_b_g", int'(GCount), 520);
      chk("ovr_b_r", int'(RCount), 0);
      ack("ovr_ack");
      chk("ovr_ack_over", int'(Overrun), 0);
      ack("idle_ack");
      start_frame();
      for (int i = 0; i < 30; i++) push(12'h00F, i);
      end_frame("ovr_c", 0, 0, 12'h0, 0);
      start_frame();
      end_frame("ovr_d", 0, 1, 12'hF00, 5);
      chk("ovr_d_over", int'(Overrun), 1);
      chk("ovr_d_risepix", int'(RCount), 1);
      start_frame();
      for (int i = 0; i < 10; i++) push(12'h0F0, i);
      end_frame("ackpub", 1, 0, 12'h0, 0);
      chk("ackpub_valid", int'(ResultValid), 1);
      chk("ackpub_over", int'(Overrun), 0);
      ack("ackpub_ack");

      // fall during COMPARE is ignored; pixels afterwards are not counted
      start_frame();
      for (int i = 0; i < 5; i++) push(12'hF00, i);
      Vsync = 1'b1;
      tick();
      m_accum = 0;
      Vsync = 1'b0;
      tick();
      tick();
      model_publish(0);
      chk_outputs("fallcmp");
      for (int i = 0; i < 10; i++) push(12'hF00, i);
      ack("fallcmp_ack");
      start_frame();
      end_frame("fallcmp_next", 0, 0, 12'h0, 0);
      chk("fallcmp_next_r", int'(RCount), 0);
      ack("fallcmp_next_ack");

      // randomized frames against the model
      for (int f = 0; f < 8; f++) begin
         int n, dom;
         logic [11:0] p;
         start_frame();
         n = $urandom_range(100, 700);
         dom = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) begin
            p = 12'($urandom);
            if (dom != 0 && $urandom_range(0, 3) != 0) begin
               case (dom)
                  1: p[11:8] = 4'hF;
                  2: p[7:4]  = 4'hF;
                  default: p[3:0] = 4'hF;
               endcase
            end
            push(p, $urandom_range(0, 26000));
            if ($urandom_range(0, 3) == 0) tick();
         end
         end_frame($sformatf("rnd%0d", f), 1'($urandom), 1'($urandom),
                   12'($urandom), $urandom_range(0, 26000));
         if ($urandom_range(0, 1) == 1) ack($sformatf("rnd%0d_ack", f));
      end
      ack("rnd_final_ack");

      // reset mid-frame discards it
      start_frame();
      for (int i = 0; i < 300; i++) push(12'hF00, i);
      do_reset("midreset");
      start_frame();
      for (int a = 0; a < NPIX; a++) push(12'h00F, a);
      end_frame("full_blue", 0, 0, 12'h0, 0);
      chk("full_blue_r", int'(RCount), 0);
      chk("full_blue_b", int'(BCount), 25344);
      chk("full_blue_c", int'(Color), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
